ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..8).
REQ-002 SHALL have parameter MAX_OUT, default 2, maximum outstanding memory requests.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  32  new fetch address (word aligned).
REQ-008 SHALL have port deq_ready  input  1  core consumes head entry.
REQ-009 SHALL have port pop2  input  1  core consumes head and second entry (fused pair).
REQ-010 SHALL have port inst_valid  output  1  head entry present.
REQ-011 SHALL have port inst_out  output  32  head instruction.
REQ-012 SHALL have port inst_pc  output  32  head instruction address.
REQ-013 SHALL have port next_valid  output  1  second entry present.
REQ-014 SHALL have port next_inst  output  32  second instruction (fusion peek).
REQ-015 SHALL have port mem_req  output  1  instruction memory request.
REQ-016 SHALL have port mem_addr  output  32  request address.
REQ-017 SHALL have port mem_gnt  input  1  request accepted this cycle.
REQ-018 SHALL have port mem_rvalid  input  1  in-order read response valid.
REQ-019 SHALL have port mem_rdata  input  32  response data.

Function
REQ-020 SHALL assert mem_req in state RUN when count + outstanding < DEPTH and outstanding < MAX_OUT; mem_addr = fpc.
REQ-021 SHALL, on mem_req && mem_gnt, increment fpc by 4 (wrap modulo 2^32) and outstanding by 1.
REQ-022 SHALL hold mem_req and mem_addr stable until mem_gnt.
REQ-023 SHALL, on mem_rvalid in RUN, push {mem_rdata, address} at tail; the entry becomes visible on inst_out the following cycle (1-cycle latency).
REQ-024 SHALL pop one entry on deq_ready && inst_valid, and pop two on pop2 && next_valid; pop2 takes priority over deq_ready.
REQ-025 SHALL support push and pop in the same cycle, count updated by net change; never overflow (guaranteed by REQ-020).
REQ-026 SHALL ignore deq_ready when empty and pop2 when fewer than two entries.
REQ-027 SHALL, on redirect, empty the queue, set fpc = redirect_pc, and have redirect win over every same-cycle push, pop, or grant.
REQ-028 SHALL, on redirect with outstanding > 0 (counting a same-cycle grant), load drop_cnt = outstanding and enter DRAIN; otherwise stay in RUN.
REQ-029 SHALL, in DRAIN, deassert mem_req, discard each mem_rvalid response, decrement drop_cnt, and return to RUN when drop_cnt reaches 0.
REQ-030 SHALL, on redirect in DRAIN, reload fpc only; drop_cnt continues.
REQ-031 SHALL keep inst_out, inst_pc, and next_inst as don't-care when the matching valid is 0.

Reset
REQ-032 SHALL, on rst low, asynchronously set state=RUN, fpc=RESET_PC, count=0, outstanding=0, drop_cnt=0, inst_valid=0, next_valid=0, mem_req=0.
REQ-033 SHALL issue the first request at RESET_PC on the first cycle after rst deasserts.
REQ-034 SHALL, on reset mid-operation, discard all entries and forget outstanding requests; the memory is reset together.

Configuration
REQ-035 SHALL, with IFQ_PEEK2_EN defined, drive next_valid and next_inst from the second entry and honour pop2.
REQ-036 SHALL, without IFQ_PEEK2_EN, tie next_valid=0 and next_inst=0 and ignore pop2.

Structure
REQ-037 SHALL place state enum {RUN, DRAIN}, default DEPTH, MAX_OUT, RESET_PC, and the entry struct {inst, pc} in package ifq_pkg.
REQ-038 SHALL implement storage as sub-module ifq_fifo (circular buffer, head/tail pointers, count, pop of 1 or 2).

Verification
REQ-039 SHALL verify reset: after rst release with mem_gnt=1 and 1-cycle rvalid, addresses 0x0, 0x4, 0x8, 0xC are requested and inst_pc=0x0 appears first.
REQ-040 SHALL verify full: with deq_ready=0, mem_req drops after 4 entries plus outstanding total 4, then a single pop yields exactly one new request.
REQ-041 SHALL verify redirect: with 2 outstanding, redirect_pc=0x100 gives inst_valid=0 next cycle, 2 responses dropped, and the next request at 0x100.
REQ-042 SHALL verify fusion pop: with entries at 0x10/0x14/0x18 and pop2=1, inst_pc=0x18 next cycle; with IFQ_PEEK2_EN undefined, next_valid stays 0.
REQ-043 SHALL verify simultaneous events: push + pop at count=DEPTH-1 keeps count; redirect + mem_gnt on the same cycle counts the granted request in drop_cnt.
REQ-044 SHALL verify wrap: fpc=0xFFFF_FFFC followed by a grant gives a next address of 0x0000_0000.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and default parameters for the instruction fetch queue.
package ifq_pkg;

    localparam int          IFQ_DEPTH    = 4;
    localparam int          IFQ_MAX_OUT  = 2;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular instruction buffer: one push and a pop of one or two entries per cycle.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  ifq_entry_t    push_data,
    input  logic          pop1,
    input  logic          pop2,
    output ifq_entry_t    head,
    output logic [31:0]   second_inst,
    output logic [CW-1:0] count
);

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    logic [CW-1:0] pop_n;

    assign pop_n = pop2 ? CW'(2) : (pop1 ? CW'(1) : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)
                tail_ptr <= tail_ptr + 1'b1;
            head_ptr <= head_ptr + AW'(pop_n);
            count    <= count + CW'(push) - pop_n;
        end
    end

    // Payload needs no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[tail_ptr] <= push_data;
    end

    assign head        = mem[head_ptr];
    assign second_inst = mem[head_ptr + 1'b1].inst;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: in-order fetch with bounded outstanding requests and redirect drain.
// Define IFQ_PEEK2_EN to expose the second entry and enable fused-pair pop.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = IFQ_DEPTH,
    parameter int          MAX_OUT  = IFQ_MAX_OUT,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    input  logic        pop2,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        next_valid,
    output logic [31:0] next_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

`ifdef IFQ_PEEK2_EN
    localparam bit PEEK2 = 1'b1;
`else
    localparam bit PEEK2 = 1'b0;
`endif

    ifq_state_e    state;
    logic [31:0]   fpc;
    logic [31:0]   rpc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [OW-1:0] out_nxt;
    logic [CW-1:0] count;
    logic          grant;
    logic          push;
    logic          pop1;
    logic          pop2_eff;
    ifq_entry_t    head;
    logic [31:0]   second_inst;

    // Requests depend only on registered state, so they hold until granted.
    assign mem_req  = rst && (state == RUN) &&
                      (int'(count) + int'(outstanding) < DEPTH) &&
                      (int'(outstanding) < MAX_OUT);
    assign mem_addr = fpc;
    assign grant    = mem_req && mem_gnt;

    assign push     = mem_rvalid && (state == RUN) && !redirect;
    assign pop2_eff = PEEK2 && pop2 && (count >= CW'(2)) && !redirect;
    assign pop1     = !pop2_eff && deq_ready && inst_valid && !redirect;
    assign out_nxt  = outstanding + OW'(grant) - OW'(mem_rvalid);

    assign inst_valid = (count != '0);
    assign inst_out   = head.inst;
    assign inst_pc    = head.pc;
    assign next_valid = PEEK2 && (count >= CW'(2));
    assign next_inst  = PEEK2 ? second_inst : '0;

    // rpc is the address owed to the next response that will be kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_nxt;
            if (grant)
                fpc <= fpc + 32'd4;
            if (push)
                rpc <= rpc + 32'd4;
            if (state == DRAIN && mem_rvalid) begin
                drop_cnt <= drop_cnt - 1'b1;
                if (drop_cnt == OW'(1))
                    state <= RUN;
            end
            if (redirect) begin
                fpc <= redirect_pc;
                rpc <= redirect_pc;
                if (state == RUN && out_nxt != '0) begin
                    state    <= DRAIN;
                    drop_cnt <= out_nxt;
                end
            end
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  ('{inst: mem_rdata, pc: rpc}),
        .pop1       (pop1),
        .pop2       (pop2_eff),
        .head       (head),
        .second_inst(second_inst),
        .count      (count)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and random checks of ifetch_queue against a request/response level queue model.
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        pop2;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        next_valid;
    logic [31:0] next_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .pop2(pop2), .inst_valid(inst_valid),
        .inst_out(inst_out), .inst_pc(inst_pc), .next_valid(next_valid),
        .next_inst(next_inst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit peek;

    // Reference model: delivered instructions, requests in flight (doomed flag + address), fetch pc.
    logic [63:0] m_q[$];
    logic [32:0] m_fly[$];
    logic [31:0] m_fpc;
    logic [31:0] mem_q[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit m_draining();
        foreach (m_fly[i]) if (m_fly[i][32]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_req();
        return !m_draining() && (m_q.size() + m_fly.size() < DEPTH) && (m_fly.size() < MAX_OUT);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e;
        chk("mem_req", 32'(mem_req), 32'(m_req()));
        if (m_req()) chk("mem_addr", mem_addr, m_fpc);
        chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            e = m_q[0];
            chk("inst_pc", inst_pc, e[31:0]);
            chk("inst_out", inst_out, e[63:32]);
        end
        chk("next_valid", 32'(next_valid), 32'(peek && m_q.size() > 1));
        if (!peek) chk("next_inst_tied", next_inst, 32'h0);
        else if (m_q.size() > 1) begin
            e = m_q[1];
            chk("next_inst", next_inst, e[63:32]);
        end
    endtask

    task automatic step(input bit gnt, input bit rv, input bit dq, input bit p2,
                        input bit rd, input logic [31:0] rpc);
        logic [32:0] f;
        bit          granted;
        @(negedge clk);
        check_outputs();
        granted     = m_req() && gnt;
        mem_gnt     = gnt;
        redirect    = rd;
        redirect_pc = rpc;
        deq_ready   = dq;
        pop2        = p2;
        mem_rvalid  = rv && (mem_q.size() > 0);
        mem_rdata   = mem_rvalid ? data_of(mem_q[0]) : $urandom();
        if (mem_req && gnt) mem_q.push_back(mem_addr);
        if (mem_rvalid) void'(mem_q.pop_front());
        if (!rd) begin
            if (peek && p2 && m_q.size() >= 2) begin
                void'(m_q.pop_front());
                void'(m_q.pop_front());
            end else if (dq && m_q.size() >= 1) begin
                void'(m_q.pop_front());
            end
        end
        if (mem_rvalid && m_fly.size() > 0) begin
            f = m_fly.pop_front();
            if (!f[32] && !rd) m_q.push_back({data_of(f[31:0]), f[31:0]});
        end
        if (granted) begin
            m_fly.push_back({1'b0, m_fpc});
            m_fpc = m_fpc + 32'd4;
        end
        if (rd) begin
            m_q.delete();
            foreach (m_fly[i]) m_fly[i][32] = 1'b1;
            m_fpc = rpc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0; deq_ready = 1'b0; pop2 = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_next_valid", 32'(next_valid), 32'h0);
        m_q.delete(); m_fly.delete(); mem_q.delete();
        m_fpc = 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0; pop2 = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef IFQ_PEEK2_EN
        peek = 1'b1;
`else
        peek = 1'b0;
`endif
        // Reset, fill to full, then one pop frees exactly one request slot.
        do_reset();
        @(negedge clk);
        chk("first_req", 32'(mem_req), 32'h1);
        chk("first_addr", mem_addr, 32'h0);
        repeat (8) step(1, 1, 0, 0, 0, 32'h0);
        step(1, 1, 1, 0, 0, 32'h0);
        repeat (4) step(1, 1, 0, 0, 0, 32'h0);

        // Redirect with two requests in flight, both responses dropped.
        do_reset();
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h100);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0);
        repeat (4) step(1, 1, 0, 0, 0, 32'h0);

        // Fused pair pop from 0x10.
        do_reset();
        step(0, 0, 0, 0, 1, 32'h10);
        repeat (5) step(1, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);

        // Push + pop at DEPTH-1, then redirect coinciding with a grant.
        do_reset();
        repeat (3) step(1, 1, 0, 0, 0, 32'h0);
        step(0, 1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h200);
        repeat (4) step(1, 1, 1, 0, 0, 32'h0);

        // Fetch pc wrap.
        do_reset();
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        repeat (5) step(1, 1, 1, 0, 0, 32'h0);

        // Random traffic with a mid-run reset.
        for (int k = 0; k < 800; k++) begin
            if (k == 400) do_reset();
            step(($urandom() % 4) != 0, ($urandom() % 3) != 0, ($urandom() % 2) == 0,
                 ($urandom() % 3) == 0, ($urandom() % 20) == 0, $urandom() & 32'hFFFF_FFFC);
        end
        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
